// File: rtl/dp_pkg.sv
// Shared definitions for the data-processing execute controller:
// opcodes, condition codes, flag bit positions and the FSM state type.
package dp_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int fN = 3;
    localparam int fZ = 2;
    localparam int fC = 1;
    localparam int fV = 0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_EXEC = 3'd2,
        ST_WB   = 3'd3,
        ST_SKIP = 3'd4
    } state_t;

    // TST/TEQ/CMP/CMN only produce flags; the result is discarded.
    function automatic logic is_compare(input logic [3:0] opcode);
        return (opcode >= OP_TST) && (opcode <= OP_CMN);
    endfunction

    // Compares reuse the ALU's ordinary AND/EOR/SUB/ADD datapaths.
    function automatic logic [3:0] map_alu_op(input logic [3:0] opcode);
        logic [3:0] op;
        case (opcode)
            OP_TST:  op = OP_AND;
            OP_TEQ:  op = OP_EOR;
            OP_CMP:  op = OP_SUB;
            OP_CMN:  op = OP_ADD;
            default: op = opcode;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/dp_cond_check.sv
// Combinational ARM condition-code evaluator against an NZCV vector.
// NV is treated as never-execute.
module dp_cond_check
    import dp_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    always_comb begin
        n    = nzcv[fN];
        z    = nzcv[fZ];
        c    = nzcv[fC];
        v    = nzcv[fV];
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/dp_exec_ctrl.sv
// Multi-cycle sequencer for one data-processing instruction: read Rn, drive ALU,
// write back Rd and NZCV. Conditional execution enabled by defining DP_COND_EXEC_EN.
module dp_exec_ctrl
    import dp_pkg::*;
#(
    parameter int RF_AW = 4,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             ins_valid,
    output logic             ins_ready,
    input  logic [3:0]       ins_cond,
    input  logic [3:0]       ins_opcode,
    input  logic             ins_s,
    input  logic [RF_AW-1:0] ins_rn,
    input  logic [RF_AW-1:0] ins_rd,
    input  logic [DW-1:0]    ins_op2,
    input  logic             ins_shift_cout,
    output logic [RF_AW-1:0] rf_raddr,
    input  logic [DW-1:0]    rf_rdata,
    output logic [DW-1:0]    alu_a,
    output logic [DW-1:0]    alu_b,
    output logic [3:0]       alu_op,
    output logic             alu_c,
    output logic             alu_v,
    output logic             alu_shift_cout,
    input  logic [DW-1:0]    alu_f,
    input  logic [3:0]       alu_nzcv,
    output logic             rf_we,
    output logic [RF_AW-1:0] rf_waddr,
    output logic [DW-1:0]    rf_wdata,
    output logic [3:0]       cpsr_nzcv,
    output logic             done,
    output logic             skipped
);

    state_t             state_q, state_d;
    logic [3:0]         opcode_q;
    logic               s_q;
    logic [RF_AW-1:0]   rn_q;
    logic [RF_AW-1:0]   rd_q;
    logic [DW-1:0]      op2_q;
    logic               shift_cout_q;
    logic [DW-1:0]      result_q;
    logic [3:0]         flags_q;
    logic [3:0]         cpsr_q, cpsr_d;
    logic               accept;
    logic               cond_pass;
    logic               commit;

`ifdef DP_COND_EXEC_EN
    dp_cond_check u_cond_check (
        .cond (ins_cond),
        .nzcv (cpsr_q),
        .pass (cond_pass)
    );
`else
    logic unused_cond;
    assign unused_cond = ^ins_cond;
    assign cond_pass   = 1'b1;
`endif

    assign accept    = ins_valid && ins_ready;
    assign cpsr_nzcv = cpsr_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = cond_pass ? ST_READ : ST_SKIP;
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            ST_SKIP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    // Architectural side effects (write, flags, done) are held off during flush or reset.
    always_comb begin
        ins_ready      = rst_n && !flush && (state_q == ST_IDLE);
        commit         = rst_n && !flush;
        rf_raddr       = '0;
        alu_a          = '0;
        alu_b          = '0;
        alu_op         = '0;
        alu_c          = 1'b0;
        alu_v          = 1'b0;
        alu_shift_cout = 1'b0;
        rf_we          = 1'b0;
        rf_waddr       = '0;
        rf_wdata       = '0;
        done           = 1'b0;
        skipped        = 1'b0;
        cpsr_d         = cpsr_q;
        case (state_q)
            ST_READ: rf_raddr = rn_q;
            ST_EXEC: begin
                alu_a          = rf_rdata;
                alu_b          = op2_q;
                alu_op         = map_alu_op(opcode_q);
                alu_c          = cpsr_q[fC];
                alu_v          = cpsr_q[fV];
                alu_shift_cout = shift_cout_q;
            end
            ST_WB: begin
                if (commit) begin
                    done = 1'b1;
                    if (!is_compare(opcode_q)) begin
                        rf_we    = 1'b1;
                        rf_waddr = rd_q;
                        rf_wdata = result_q;
                    end
                    if (s_q || is_compare(opcode_q)) cpsr_d = flags_q;
                end
            end
            ST_SKIP: begin
                done = commit;
`ifdef DP_COND_EXEC_EN
                skipped = commit;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cpsr_q       <= '0;
            opcode_q     <= '0;
            s_q          <= 1'b0;
            rn_q         <= '0;
            rd_q         <= '0;
            op2_q        <= '0;
            shift_cout_q <= 1'b0;
            result_q     <= '0;
            flags_q      <= '0;
        end else begin
            state_q <= state_d;
            cpsr_q  <= cpsr_d;
            if (accept) begin
                opcode_q     <= ins_opcode;
                s_q          <= ins_s;
                rn_q         <= ins_rn;
                rd_q         <= ins_rd;
                op2_q        <= ins_op2;
                shift_cout_q <= ins_shift_cout;
            end
            if (state_q == ST_EXEC) begin
                result_q <= alu_f;
                flags_q  <= alu_nzcv;
            end
        end
    end

endmodule

// File: doc/dp_exec_ctrl.md
Name: dp_exec_ctrl

Overview:
Multi-cycle sequencer for the ARM-style data-processing datapath. Accepts one decoded data-processing instruction per handshake, reads Rn from the register file, drives the shared combinational ALU, and writes back Rd and the CPSR NZCV flags. Sits between the decoder/issue stage and the ALU + register file, and owns the architectural NZCV register.

Parameters:
RF_AW, 4, register-file address width (16 registers)
DW, 32, datapath width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  abort in-flight instruction, no writeback
ins_valid  in  1  instruction offered
ins_ready  out  1  controller can accept
ins_cond  in  4  ARM condition field
ins_opcode  in  4  ARM DP opcode (0 AND … F MVN)
ins_s  in  1  S bit, update flags
ins_rn  in  RF_AW  first operand register
ins_rd  in  RF_AW  destination register
ins_op2  in  DW  pre-shifted second operand
ins_shift_cout  in  1  shifter carry-out for op2
rf_raddr  out  RF_AW  register-file read address
rf_rdata  in  DW  read data, valid the cycle after rf_raddr
alu_a  out  DW  ALU operand A
alu_b  out  DW  ALU operand B
alu_op  out  4  ALU operation select
alu_c  out  1  carry-in to ALU (CPSR C)
alu_v  out  1  V passthrough to ALU (CPSR V)
alu_shift_cout  out  1  shifter carry to ALU
alu_f  in  DW  ALU result
alu_nzcv  in  4  ALU flags {N,Z,C,V}
rf_we  out  1  register write strobe
rf_waddr  out  RF_AW  write address
rf_wdata  out  DW  write data
cpsr_nzcv  out  4  architectural flags
done  out  1  one-cycle pulse, instruction retired
skipped  out  1  with done: condition failed, nothing written

Behaviour:
- Reset: state IDLE; cpsr_nzcv=0000; ins_ready=0 during reset, 1 the first cycle after; rf_we, done, skipped, alu_op, alu_a, alu_b, rf_raddr, rf_waddr, rf_wdata all 0.
- States IDLE, READ, EXEC, WB, SKIP. ins_ready=1 only in IDLE with flush=0.
- IDLE: on ins_valid&ins_ready, latch instruction fields; if condition passes against current cpsr_nzcv -> READ, else -> SKIP.
- READ: rf_raddr=ins_rn -> EXEC.
- EXEC: alu_a=rf_rdata, alu_b=op2, alu_c/alu_v = CPSR C/V, alu_shift_cout = latched value; register alu_f and alu_nzcv -> WB.
- WB: done=1. rf_we=1 with rf_waddr=rd and rf_wdata=result unless the opcode is a compare (8–B). cpsr_nzcv <= registered flags if ins_s=1 or compare. -> IDLE.
- SKIP: done=1, skipped=1, no writes -> IDLE.
- Latency: accept at cycle T, done at T+3 (executed) or T+1 (skipped). Throughput one instruction per 4 cycles.
- Opcode -> alu_op map: 8 TST->0, 9 TEQ->1, A CMP->2, B CMN->4; all other opcodes pass through unchanged.
- Condition codes: full ARM EQ..AL evaluation; NV (F) is treated as fail.
- flush in READ/EXEC/WB: no rf_we, no flag update, no done; IDLE next cycle. flush in IDLE blocks acceptance. A flush in the same cycle as a WB suppresses that writeback.
- rst_n low in any state: takes effect at the next edge; in-flight instruction dropped, no write.
- rd=15 is written like any other register; PC semantics are not this block's concern.

Optional Feature:
DP_COND_EXEC_EN. When defined, conditional execution is active as described above. When undefined, ins_cond is ignored, every instruction executes, SKIP is unreachable, and skipped is tied to 0.

Decomposition:
- Package dp_pkg holds: opcode localparams (OP_AND..OP_MVN), condition localparams (COND_EQ..COND_NV), NZCV bit indices (fN=3, fZ=2, fC=1, fV=0), state encoding, and an is_compare function.
- Sub-module dp_cond_check: combinational, inputs cond[3:0] and nzcv[3:0], output pass.

Test Plan:
- Reset then ADD r1=5 (op2=7, s=1, cond AL) -> done at T+3, rf_we with rd=r1, wdata=0x0000000C; cpsr_nzcv=0000.
- CMP with rn=3 and op2=3 -> no rf_we; cpsr_nzcv=0110 (Z=1, C=1); alu_op observed as 2 in EXEC.
- EQ-conditioned MOV with Z=0 -> done and skipped at T+1; no rf_we; flags unchanged. Repeat with Z=1 -> executes.
- ADC with C=1, rn=0xFFFFFFFF, op2=0, s=1 -> wdata=0; cpsr_nzcv=0110; alu_c=1 driven in EXEC.
- flush asserted in EXEC -> no rf_we, no done, ins_ready=1 next cycle; back-to-back issue accepted.
- rst_n low during WB -> no write; all outputs 0 and cpsr_nzcv=0000 next cycle.
